zigzag_stream: RTL

Streaming, double-buffered 8x8 zigzag reorder unit for the JPEG datapath. It accepts one DW-bit coefficient per cycle over a valid/ready handshake and emits the same 64-sample block in reordered sequence. Per block it runs in forward mode (raster in, zigzag out; sits after quantiser) or inverse mode (zigzag in, raster out; sits before dequantiser). Ping-pong banks sustain 1 sample/cycle with no bubbles between blocks.

---
 rtl/zigzag_pkg.sv | 23 ++
 rtl/zigzag_bank.sv | 25 ++
 rtl/zigzag_stream.sv | 112 +++++++++++
 3 files changed

// File: rtl/zigzag_pkg.sv
// Shared constants, mode type and zigzag address helper for the 8x8 reorder unit.
package zigzag_pkg;

    localparam int unsigned BLK = 64;

    // Raster index (row*8+col) of the j-th coefficient in JPEG zigzag order.
    localparam int ZZ [BLK] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic {
        ZZ_FWD = 1'b0,
        ZZ_INV = 1'b1
    } zz_mode_e;

    function automatic logic [5:0] zz_addr(input logic [5:0] j);
        return 6'(ZZ[j]);
    endfunction

endpackage

// File: rtl/zigzag_bank.sv
// One 64-entry coefficient bank: single synchronous write port, combinational read port.
module zigzag_bank
    import zigzag_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [5:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [5:0]    raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [BLK];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/zigzag_stream.sv
// Double-buffered 8x8 zigzag reorder: forward (raster in, zigzag out) or inverse per block.
module zigzag_stream
    import zigzag_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_mode
);

    logic [1:0]    full;
    logic          wr_sel;
    logic          rd_sel;
    logic [5:0]    wr_cnt;
    logic [5:0]    rd_cnt;
    zz_mode_e      mode_q [2];

    logic          wr_fire;
    logic          rd_load;
    logic          wr_inv;
    logic          rd_inv;
    logic [5:0]    waddr;
    logic [5:0]    raddr;
    logic [1:0]    we;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rd_data;

    assign in_ready = !full[wr_sel];
    assign wr_fire  = in_valid && in_ready;
    assign rd_load  = full[rd_sel] && (!out_valid || out_ready);

    always_comb begin
        // Sample 0 takes its mode straight from in_mode; mode_q is written on that same edge.
        wr_inv  = (wr_cnt == '0) ? in_mode : (mode_q[wr_sel] == ZZ_INV);
        waddr   = wr_inv ? zz_addr(wr_cnt) : wr_cnt;
        rd_inv  = (mode_q[rd_sel] == ZZ_INV);
        raddr   = rd_inv ? rd_cnt : zz_addr(rd_cnt);
        we      = '0;
        we[wr_sel] = wr_fire;
        rd_data = rd_sel ? rdata1 : rdata0;
    end

    zigzag_bank #(.DW(DW)) u_bank0 (
        .clk   (clk),
        .we    (we[0]),
        .waddr (waddr),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata0)
    );

    zigzag_bank #(.DW(DW)) u_bank1 (
        .clk   (clk),
        .we    (we[1]),
        .waddr (waddr),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            mode_q[0] <= ZZ_FWD;
            mode_q[1] <= ZZ_FWD;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_mode  <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_cnt == '0) begin
                    mode_q[wr_sel] <= in_mode ? ZZ_INV : ZZ_FWD;
                end
                wr_cnt <= wr_cnt + 6'd1;
                if (wr_cnt == 6'd63) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= ~wr_sel;
                end
            end

            if (rd_load) begin
                out_valid <= 1'b1;
                out_data  <= rd_data;
                out_last  <= (rd_cnt == 6'd63);
                out_mode  <= rd_inv;
                rd_cnt    <= rd_cnt + 6'd1;
                if (rd_cnt == 6'd63) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
